// File: rtl/fft16_pkg.sv
// fft16_pkg: shared constants, bank-state encoding and digit-reversal helper for the FFT16 loader
package fft16_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int N_PTS      = 16;
    localparam int LANES      = 16;
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_st_t;
    // radix-4 digit reversal: sample 4a+b lands on lane 4b+a
    function automatic logic [3:0] digrev(input logic [3:0] n);
        return {n[1:0], n[3:2]};
    endfunction
endpackage

// File: rtl/fft16_frame_bank.sv
// fft16_frame_bank: one 16-lane complex register bank with lane-indexed write and synchronous clear
//   clk, rst      : clock, synchronous active-high reset (clears all lanes)
//   clr           : clears all lanes (discarded partial frame)
//   we, lane      : write enable and target lane for wr_re/wr_im
//   out_re/out_im : lane k at [k*DATA_W +: DATA_W]
module fft16_frame_bank
    import fft16_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    we,
    input  logic [3:0]              lane,
    input  logic [DATA_W-1:0]       wr_re,
    input  logic [DATA_W-1:0]       wr_im,
    output logic [LANES*DATA_W-1:0] out_re,
    output logic [LANES*DATA_W-1:0] out_im
);
    logic [DATA_W-1:0] re_q [LANES];
    logic [DATA_W-1:0] im_q [LANES];
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < LANES; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (we) begin
            re_q[lane] <= wr_re;
            im_q[lane] <= wr_im;
        end
    end
    genvar k;
    for (k = 0; k < LANES; k++) begin : g_lane
        assign out_re[k*DATA_W +: DATA_W] = re_q[k];
        assign out_im[k*DATA_W +: DATA_W] = im_q[k];
    end
endmodule

// File: rtl/fft16_input_loader.sv
// fft16_input_loader: ping-pong frame assembler presenting 16 samples in radix-4 digit-reversed lane order
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready           : sample stream handshake; in_re/in_im sample, in_last marks sample 15
//   out_valid/out_ready         : frame handshake; out_re/out_im lane k at [k*DATA_W +: DATA_W]
//   frame_err                   : one-cycle pulse after a sample with misplaced or missing in_last
//   FFT16_LOADER_PRESCALE_EN    : when defined, stored components are arithmetically shifted right by 2
module fft16_input_loader
    import fft16_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_PTS  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_re,
    input  logic [DATA_W-1:0]       in_im,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_re,
    output logic [LANES*DATA_W-1:0] out_im,
    output logic                    frame_err
);
    if (N_PTS != fft16_pkg::N_PTS) begin : g_bad_npts
        $error("fft16_input_loader supports only N_PTS=16");
    end
    bank_st_t st [2];
    bank_st_t st_nxt [2];
    logic [3:0] cnt, cnt_nxt;
    logic wb, rb, wb_nxt, rb_nxt, err_nxt;
    logic acc, drain, last_idx, discard;
    logic [DATA_W-1:0] wr_re, wr_im;
    logic [LANES*DATA_W-1:0] b_re [2];
    logic [LANES*DATA_W-1:0] b_im [2];
    assign in_ready  = st[wb] != FULL;
    assign out_valid = st[rb] == FULL;
    assign acc       = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last_idx  = cnt == 4'd15;
    assign discard   = acc && in_last && !last_idx;
`ifdef FFT16_LOADER_PRESCALE_EN
    assign wr_re = DATA_W'($signed(in_re) >>> 2);
    assign wr_im = DATA_W'($signed(in_im) >>> 2);
`else
    assign wr_re = in_re;
    assign wr_im = in_im;
`endif
    genvar b;
    for (b = 0; b < 2; b++) begin : g_bank
        fft16_frame_bank #(.DATA_W(DATA_W)) u_bank (
            .clk    (clk),
            .rst    (rst),
            .clr    (discard && (wb == 1'(b))),
            .we     (acc && (wb == 1'(b))),
            .lane   (digrev(cnt)),
            .wr_re  (wr_re),
            .wr_im  (wr_im),
            .out_re (b_re[b]),
            .out_im (b_im[b])
        );
    end
    assign out_re = b_re[rb];
    assign out_im = b_im[rb];
    // drain and fill never target the same bank: drain needs FULL, fill needs not FULL
    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        wb_nxt  = wb;
        rb_nxt  = rb;
        err_nxt = 1'b0;
        if (drain) begin
            st_nxt[rb] = EMPTY;
            rb_nxt     = !rb;
        end
        if (acc) begin
            err_nxt = in_last != last_idx;
            if (discard) begin
                st_nxt[wb] = EMPTY;
                cnt_nxt    = '0;
            end else if (last_idx) begin
                st_nxt[wb] = FULL;
                cnt_nxt    = '0;
                wb_nxt     = !wb;
            end else begin
                st_nxt[wb] = FILLING;
                cnt_nxt    = cnt + 4'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st[0]     <= EMPTY;
            st[1]     <= EMPTY;
            cnt       <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            wb        <= wb_nxt;
            rb        <= rb_nxt;
            frame_err <= err_nxt;
        end
    end
endmodule

// File: doc/fft16_input_loader.md
Name: fft16_input_loader

Overview:
Front-end feeder for the 16-point radix-4 FFT. It accepts one complex sample per cycle over a valid/ready stream and assembles 16-sample frames in a ping-pong pair of register banks. Each completed frame is presented as one 16-lane parallel word in radix-4 digit-reversed order, ready for the first-stage radix-4 butterfly. Lanes 4g..4g+3 form the input group of butterfly g.

Parameters:
DATA_W, 16, bit width of each real and imaginary component (two's complement).
N_PTS, 16, frame length. Fixed at 16; any other value is a compile-time error.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input sample valid.
in_ready  out  1  loader can accept a sample this cycle.
in_re  in  DATA_W  sample real part.
in_im  in  DATA_W  sample imaginary part.
in_last  in  1  marks the final sample (index 15) of a frame.
out_valid  out  1  a complete frame is presented.
out_ready  in  1  downstream butterfly stage accepts the frame.
out_re  out  16*DATA_W  lane k real part at [k*DATA_W +: DATA_W].
out_im  out  16*DATA_W  lane k imaginary part, same packing.
frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: in_ready=1, out_valid=0, out_re=0, out_im=0, frame_err=0. Sample count=0, both banks empty, write bank=0, read bank=0.
- Reset mid-frame: any partial or full frame is discarded. No output transfer completes in the reset cycle.
- Input transfer: in_valid && in_ready. Sample n (count 0..15) is written to lane digrev(n), where digrev(4a+b)=4b+a.
  - Lanes 0..3 therefore hold samples 0,4,8,12; lanes 4..7 hold 1,5,9,13; and so on.
- Bank states are EMPTY, FILLING and FULL; the write bank moves EMPTY -> FILLING -> FULL.
  - in_ready=1 while the write bank is not FULL.
  - When the 16th sample is accepted, that bank becomes FULL, count wraps to 0, and the write bank toggles.
  - If the other bank is still FULL, in_ready drops to 0 in the next cycle.
- Output: out_valid=1 while the read bank is FULL. out_re/out_im are driven from registers of the read bank.
  - On out_valid && out_ready, the read bank becomes EMPTY and the read bank toggles.
- Latency: out_valid rises the cycle after the 16th sample is accepted.
- Throughput: with out_ready held at 1, the loader sustains 1 sample/cycle with no bubbles.
- Stability: while out_valid && !out_ready, out_re, out_im and out_valid hold their values unchanged.
- Simultaneous events: the 16th sample may land in one bank in the same cycle the other bank is drained. Both take effect.
  - in_ready then stays 1.
- Backpressure: with both banks FULL, in_ready=0. in_valid is ignored and the count holds.
- Framing:
  - in_last on an accepted sample with count != 15: the partial frame is discarded, count=0, the bank returns to EMPTY, and frame_err pulses.
  - Count 15 accepted with in_last=0: the frame completes normally and frame_err pulses.
- No arithmetic is performed; widths are preserved unless the optional feature is compiled in.

Optional Feature:
- Macro: FFT16_LOADER_PRESCALE_EN.
- Defined: each stored component equals the input arithmetically shifted right by 2 (sign-extended, truncated toward minus infinity). This provides two guard bits for radix-4 growth.
  - Example: in_re=16'h7FFC stores 16'h1FFF; in_re=16'h8000 stores 16'hE000.
- Undefined: components are stored unmodified.

Decomposition:
- Package fft16_pkg:
  - DATA_W default and N_PTS=16.
  - LANES=16.
  - 4-bit digrev function (or a 16-entry constant table).
  - Bank-state encoding EMPTY=2'd0, FILLING=2'd1, FULL=2'd2.
- Sub-module fft16_frame_bank: one 16x(2*DATA_W) register bank with a lane-indexed write enable, a clear input, and flat out_re/out_im buses. It is instantiated twice, and the top-level multiplexes the read bank onto the outputs.

Test Plan:
- Stream samples re=n, im=-n for n=0..15 with in_last on n=15 and out_ready=1 -> out_valid rises at cycle 17. Lanes 0..3 re = 0,4,8,12; lane 5 re=5; lane 15 re=15; frame_err never pulses.
- Three back-to-back frames with out_ready=0 -> in_ready falls after sample 32; the third frame stalls at count 0. Raise out_ready for one cycle -> frame 1 leaves, and frame 2 is presented next cycle unchanged.
- in_last asserted on sample index 7 -> frame_err pulses once and no frame is output. A following clean 16-sample frame outputs correctly.
- rst asserted for one cycle after 9 samples -> all outputs return to reset values. The next 16 samples form a correct frame starting at lane 0.
- Continuous 64 samples with out_ready=1 -> in_ready stays 1 throughout and 4 frames are output at 16-cycle spacing. With FFT16_LOADER_PRESCALE_EN, input 16'h8000 appears as 16'hE000.
